// File: rtl/aes_gcm_pkg.sv
// Shared types and constants for the AES-GCM tag finalisation block.
// Blocks use GCM bit order: index 0 is the leftmost (most significant) bit of the
// hex representation, which is also the x^0 coefficient of the field element.
package aes_gcm_pkg;

  typedef logic [0:127] block_t;

  // Reduction constant: 0xE1 followed by 120 zero bits.
  localparam block_t GCM_R = {8'hE1, 120'h0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    OUT  = 2'd2
  } tag_state_e;

endpackage

// File: rtl/gf128_mult_digit.sv
// One digit step of the bit-serial GF(2^128) multiplier.
// Processes DIGIT_BITS bits of the X operand, bit 0 of the digit first.
module gf128_mult_digit
  import aes_gcm_pkg::*;
#(
  parameter int DIGIT_BITS = 8
) (
  input  logic [0:127]            z,
  input  logic [0:127]            v,
  input  logic [0:DIGIT_BITS-1]   x_digit,
  output logic [0:127]            z_next,
  output logic [0:127]            v_next
);

  block_t z_acc_s;
  block_t v_acc_s;

  // Unrolled multiply steps: conditionally accumulate V, then multiply V by x.
  always_comb begin
    z_acc_s = z;
    v_acc_s = v;
    for (int i = 0; i < DIGIT_BITS; i++) begin
      z_acc_s = z_acc_s ^ (v_acc_s & {128{x_digit[i]}});
      v_acc_s = (v_acc_s >> 1) ^ (GCM_R & {128{v_acc_s[127]}});
    end
  end

  assign z_next = z_acc_s;
  assign v_next = v_acc_s;

endmodule

// File: rtl/aes_gcm_tag_final.sv
// Final GCM tag stage: multiplies (S ^ len block) by H, XORs in E(K,J0),
// truncates the tag and optionally compares it against a received tag.
// One request in flight; result is held until the consumer takes it.
module aes_gcm_tag_final
  import aes_gcm_pkg::*;
#(
  parameter int DIGIT_BITS = 8,
  parameter int TAG_BITS   = 128,
  parameter int CH_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [0:127]          i_sblock,
  input  logic [0:127]          i_len_block,
  input  logic [0:127]          i_h,
  input  logic [0:127]          i_encrypted_j0,
  input  logic                  i_verify,
  input  logic [0:TAG_BITS-1]   i_expected_tag,
  input  logic [CH_W-1:0]       i_ch_id,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic [0:TAG_BITS-1]   o_tag,
  output logic                  o_auth_ok,
  output logic [CH_W-1:0]       o_ch_id,
  output logic                  o_busy
);

  localparam int N     = 128 / DIGIT_BITS;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  tag_state_e            state_r;
  tag_state_e            state_next_s;
  logic [CNT_W-1:0]      cnt_r;
  block_t                x_r;
  block_t                z_r;
  block_t                v_r;
  block_t                j0_r;
  logic [0:TAG_BITS-1]   exp_r;
  logic                  verify_r;
  logic [CH_W-1:0]       ch_r;

  block_t                z_next_s;
  block_t                v_next_s;
  block_t                tag_full_s;
  logic [0:TAG_BITS-1]   tag_s;
  logic                  accept_s;
  logic                  last_s;
  logic                  consume_s;

  assign accept_s   = i_valid && (state_r == IDLE);
  assign last_s     = (state_r == MULT) && (cnt_r == CNT_LAST);
  assign consume_s  = (state_r == OUT) && i_out_ready;
  assign tag_full_s = z_next_s ^ j0_r;
  assign tag_s      = tag_full_s[0:TAG_BITS-1];

  assign o_ready = (state_r == IDLE);
  assign o_busy  = (state_r != IDLE);

  // X is shifted left each cycle, so the current digit always sits at the top.
  gf128_mult_digit #(
    .DIGIT_BITS (DIGIT_BITS)
  ) u_mult (
    .z       (z_r),
    .v       (v_r),
    .x_digit (x_r[0:DIGIT_BITS-1]),
    .z_next  (z_next_s),
    .v_next  (v_next_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: accept in IDLE, N multiply cycles, hold in OUT until taken.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_valid) state_next_s = MULT;
        else         state_next_s = IDLE;
      end
      MULT: begin
        if (cnt_r == CNT_LAST) state_next_s = OUT;
        else                   state_next_s = MULT;
      end
      OUT: begin
        if (i_out_ready) state_next_s = IDLE;
        else             state_next_s = OUT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Request capture and multiplier datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      x_r      <= '0;
      z_r      <= '0;
      v_r      <= '0;
      j0_r     <= '0;
      exp_r    <= '0;
      verify_r <= 1'b0;
      ch_r     <= '0;
    end else if (accept_s) begin
      cnt_r    <= '0;
      x_r      <= i_sblock ^ i_len_block;
      z_r      <= '0;
      v_r      <= i_h;
      j0_r     <= i_encrypted_j0;
      exp_r    <= i_expected_tag;
      verify_r <= i_verify;
      ch_r     <= i_ch_id;
    end else if (state_r == MULT) begin
      cnt_r <= cnt_r + CNT_W'(1);
      x_r   <= x_r << DIGIT_BITS;
      z_r   <= z_next_s;
      v_r   <= v_next_s;
    end
  end

  // Result registers: loaded on the final multiply step, held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_tag     <= '0;
      o_auth_ok <= 1'b0;
      o_ch_id   <= '0;
    end else if (last_s) begin
      o_valid   <= 1'b1;
      o_tag     <= tag_s;
      o_auth_ok <= verify_r && (tag_s == exp_r);
      o_ch_id   <= ch_r;
    end else if (consume_s) begin
      o_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_gcm_tag_final.sv
// Directed bench for aes_gcm_tag_final: NIST vectors, hand-derived field
// products, verify pass/fail, backpressure, mid-operation reset, all digit
// widths and a 96-bit tag build.
module tb_aes_gcm_tag_final;

  localparam int CH_W = 4;
  localparam int N    = 16;   // 128 / default DIGIT_BITS

  localparam logic [127:0] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] J01  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] HONE = 128'h80000000000000000000000000000000;
  localparam logic [127:0] HX   = 128'h40000000000000000000000000000000;
  localparam logic [127:0] PAT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] S2   = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] L2   = 128'h00000000000000000000000000000080;
  localparam logic [127:0] T2   = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [0:127]      i_sblock = '0;
  logic [0:127]      i_len_block = '0;
  logic [0:127]      i_h = '0;
  logic [0:127]      i_j0 = '0;
  logic              i_verify = 1'b0;
  logic [0:127]      i_exp = '0;
  logic [CH_W-1:0]   i_ch = '0;
  logic              o_valid;
  logic              i_out_ready = 1'b0;
  logic [0:127]      o_tag;
  logic              o_auth_ok;
  logic [CH_W-1:0]   o_ch_id;
  logic              o_busy;

  aes_gcm_tag_final dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sblock(i_sblock), .i_len_block(i_len_block), .i_h(i_h),
    .i_encrypted_j0(i_j0), .i_verify(i_verify), .i_expected_tag(i_exp),
    .i_ch_id(i_ch), .o_valid(o_valid), .i_out_ready(i_out_ready),
    .o_tag(o_tag), .o_auth_ok(o_auth_ok), .o_ch_id(o_ch_id), .o_busy(o_busy)
  );

  // One instance per legal digit width, always draining its result.
  logic              aux_valid = 1'b0;
  logic              aux_rdy  [5];
  logic              aux_vo   [5];
  logic [0:127]      aux_tag  [5];
  logic              aux_ok   [5];
  logic [CH_W-1:0]   aux_ch   [5];
  logic              aux_busy [5];
  int                aux_lat  [5];

  for (genvar g = 0; g < 5; g++) begin : g_aux
    aes_gcm_tag_final #(.DIGIT_BITS(1 << g)) u_aux (
      .clk(clk), .rst_n(rst_n), .i_valid(aux_valid), .o_ready(aux_rdy[g]),
      .i_sblock(i_sblock), .i_len_block(i_len_block), .i_h(i_h),
      .i_encrypted_j0(i_j0), .i_verify(i_verify), .i_expected_tag(i_exp),
      .i_ch_id(i_ch), .o_valid(aux_vo[g]), .i_out_ready(1'b1),
      .o_tag(aux_tag[g]), .o_auth_ok(aux_ok[g]), .o_ch_id(aux_ch[g]),
      .o_busy(aux_busy[g])
    );
  end

  // 96-bit tag build.
  logic              t96_valid = 1'b0;
  logic              t96_rdy;
  logic [0:95]       t96_exp = '0;
  logic              t96_vo;
  logic [0:95]       t96_tag;
  logic              t96_ok;
  logic [CH_W-1:0]   t96_ch;
  logic              t96_busy;

  aes_gcm_tag_final #(.TAG_BITS(96)) dut96 (
    .clk(clk), .rst_n(rst_n), .i_valid(t96_valid), .o_ready(t96_rdy),
    .i_sblock(i_sblock), .i_len_block(i_len_block), .i_h(i_h),
    .i_encrypted_j0(i_j0), .i_verify(i_verify), .i_expected_tag(t96_exp),
    .i_ch_id(i_ch), .o_valid(t96_vo), .i_out_ready(1'b1),
    .o_tag(t96_tag), .o_auth_ok(t96_ok), .o_ch_id(t96_ch), .o_busy(t96_busy)
  );

  int errors = 0;
  int checks = 0;
  logic [127:0] prev_tag = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic set_req(input logic [127:0] s, input logic [127:0] len, input logic [127:0] h,
                         input logic [127:0] j0, input logic vfy, input logic [127:0] ex,
                         input logic [CH_W-1:0] ch);
    i_sblock = s; i_len_block = len; i_h = h; i_j0 = j0;
    i_verify = vfy; i_exp = ex; i_ch = ch;
  endtask

  // Issue the staged request on the main DUT, check latency and result, drain it.
  task automatic run_main(input string name, input logic [127:0] want_tag, input logic want_ok,
                          input logic [CH_W-1:0] want_ch, input logic hold_ready);
    int cyc;
    check({name, " ready_idle"}, {127'd0, o_ready}, 128'd1);
    i_valid = 1'b1;
    i_out_ready = hold_ready;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check({name, " busy"}, {126'd0, o_busy, o_ready}, 128'd2);
    check({name, " tag_held_mult"}, o_tag, prev_tag);
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 128'(cyc), 128'(N));
    check({name, " tag"}, o_tag, want_tag);
    check({name, " auth_ok"}, {127'd0, o_auth_ok}, {127'd0, want_ok});
    check({name, " ch_id"}, {124'd0, o_ch_id}, {124'd0, want_ch});
    i_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_out_ready = 1'b0;
    check({name, " drained"}, {126'd0, o_valid, o_ready}, 128'd1);
    prev_tag = want_tag;
  endtask

  initial begin
    int cyc;
    logic seen;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset outputs", {o_tag, o_valid, o_auth_ok, o_ch_id, o_busy}, '0);
    rst_n = 1'b1;
    #1;
    check("ready after reset", {127'd0, o_ready}, 128'd1);

    // NIST test case 1, encrypt, result consumed on first OUT cycle.
    set_req('0, '0, H1, J01, 1'b0, J01, 4'd1);
    run_main("tc1_enc", J01, 1'b0, 4'd1, 1'b1);
    set_req('0, '0, H1, J01, 1'b1, J01, 4'd2);
    run_main("tc1_verify_ok", J01, 1'b1, 4'd2, 1'b0);
    set_req('0, '0, H1, J01, 1'b1, J01 ^ 128'd1, 4'd3);
    run_main("tc1_verify_bad", J01, 1'b0, 4'd3, 1'b0);

    // Identity multiply with X split across S and the length block.
    set_req(128'h0123456789abcdef0000000000000000, 128'h0000000000000000fedcba9876543210,
            HONE, '0, 1'b1, PAT, 4'd4);
    run_main("identity", PAT, 1'b1, 4'd4, 1'b0);

    // Multiply by x: plain right shift, then a shift that needs reduction.
    set_req(PAT, '0, HX, '0, 1'b0, '0, 4'd5);
    run_main("times_x", 128'h0091a2b3c4d5e6f7ff6e5d4c3b2a1908, 1'b0, 4'd5, 1'b1);
    set_req(128'd1, '0, HX, '0, 1'b0, '0, 4'd6);
    run_main("reduce", 128'he1000000000000000000000000000000, 1'b0, 4'd6, 1'b0);

    // NIST test case 2 final GHASH step.
    set_req(S2, L2, H1, J01, 1'b1, T2, 4'd7);
    run_main("tc2", T2, 1'b1, 4'd7, 1'b0);

    // Backpressure: hold OUT for 10 cycles while a new request is offered.
    set_req(S2, L2, H1, J01, 1'b0, '0, 4'd10);
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("bp latency", 128'(cyc), 128'(N));
    set_req(PAT, '0, HONE, '0, 1'b0, '0, 4'd11);
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      check("bp hold", {o_tag, o_valid, o_ready, o_ch_id}, {T2, 1'b1, 1'b0, 4'd10});
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_out_ready = 1'b0;
    check("bp drained", {126'd0, o_valid, o_ready}, 128'd1);
    repeat (3) @(negedge clk);
    check("bp no ghost accept", {127'd0, o_busy}, 128'd0);
    prev_tag = T2;
    run_main("bp second", PAT, 1'b0, 4'd11, 1'b0);

    // Reset in the middle of MULT.
    set_req(S2, L2, H1, J01, 1'b1, T2, 4'd12);
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (N / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset outputs", {o_tag, o_valid, o_auth_ok, o_ch_id, o_busy}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset ready", {127'd0, o_ready}, 128'd1);
    seen = 1'b0;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      seen = seen | o_valid;
    end
    check("midreset no valid", {127'd0, seen}, 128'd0);
    prev_tag = '0;
    set_req(S2, L2, H1, J01, 1'b1, T2, 4'd13);
    run_main("after reset", T2, 1'b1, 4'd13, 1'b0);

    // Identity product for every legal digit width.
    set_req(PAT, '0, HONE, '0, 1'b0, '0, 4'd14);
    for (int g = 0; g < 5; g++) aux_lat[g] = 0;
    aux_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    aux_valid = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++) begin
        if (aux_vo[g] === 1'b1 && aux_lat[g] == 0) aux_lat[g] = k;
      end
    end
    for (int g = 0; g < 5; g++) begin
      check($sformatf("digit%0d latency", 1 << g), 128'(aux_lat[g]), 128'(128 >> g));
      check($sformatf("digit%0d tag", 1 << g), aux_tag[g], PAT);
    end

    // 96-bit tag build with test case 1.
    set_req('0, '0, H1, J01, 1'b1, '0, 4'd15);
    t96_exp = 96'h58e2fccefa7e3061367f1d57;
    t96_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t96_valid = 1'b0;
    cyc = 0;
    while (t96_vo !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("tag96 latency", 128'(cyc), 128'(N));
    check("tag96 tag", {32'd0, t96_tag}, {32'd0, 96'h58e2fccefa7e3061367f1d57});
    check("tag96 auth_ok", {123'd0, t96_ok, t96_ch}, {123'd0, 1'b1, 4'd15});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_gcm_tag_final.md
AES_GCM_TAG_FINAL -- requirements
Module: aes_gcm_tag_final

Interface
REQ-001 SHALL have parameter DIGIT_BITS, default 8: GHASH bits processed per multiply cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter TAG_BITS, default 128: emitted tag width; legal values 32, 64, 96, 104, 112, 120, 128.
REQ-003 SHALL have parameter CH_W, default 4: channel-ID width.
REQ-004 Ports; clock and reset first:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block accepts a request.
- i_sblock  in  [0:127]  GHASH state before the length block.
- i_len_block  in  [0:127]  len(A)||len(C) block.
- i_h  in  [0:127]  hash subkey H.
- i_encrypted_j0  in  [0:127]  E(K,J0).
- i_verify  in  1  1 = decrypt/verify, 0 = encrypt.
- i_expected_tag  in  [0:TAG_BITS-1]  received tag, used when i_verify=1.
- i_ch_id  in  CH_W  channel ID.
- o_valid  out  1  result valid.
- i_out_ready  in  1  downstream accepts the result.
- o_tag  out  [0:TAG_BITS-1]  computed tag, truncated.
- o_auth_ok  out  1  tag matched; 0 when not verifying.
- o_ch_id  out  CH_W  channel ID of the result.
- o_busy  out  1  state not IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, MULT, OUT.
REQ-006 o_ready SHALL be 1 only in IDLE; acceptance = i_valid && o_ready at a rising clk edge.
REQ-007 On acceptance the block SHALL capture:
- X = i_sblock ^ i_len_block.
- V = i_h, Z = 0.
- i_encrypted_j0, i_expected_tag, i_verify, i_ch_id.
- Counter = 0.
- State goes to MULT.
REQ-008 Each MULT cycle SHALL process X bits [cnt*DIGIT_BITS +: DIGIT_BITS] in ascending index order (bit 0 first). Per bit i:
- if X[i] = 1, Z ^= V;
- V = V[127] ? (V>>1) ^ R : V>>1, with R = 0xE1 followed by 120 zero bits (NIST SP800-38D Algorithm 1 bit order).
REQ-009 MULT SHALL last exactly N = 128/DIGIT_BITS cycles, then move to OUT.
REQ-010 o_valid SHALL rise exactly N cycles after the acceptance edge.
REQ-011 On the MULT-to-OUT edge the block SHALL register:
- o_tag = (Z ^ J0)[0:TAG_BITS-1];
- o_auth_ok = i_verify_captured && (o_tag == expected);
- o_ch_id.
REQ-012 In OUT, o_valid SHALL be 1 and o_tag, o_auth_ok, o_ch_id SHALL hold stable until i_out_ready = 1.
REQ-013 On an edge with o_valid && i_out_ready, state SHALL return to IDLE and o_valid SHALL fall; o_ready rises in the next cycle. Minimum initiation interval = N+2 cycles.
REQ-014 i_valid SHALL be ignored outside IDLE; no request SHALL be dropped or duplicated.
REQ-015 Outputs SHALL stay unchanged in IDLE and MULT.
REQ-016 If i_out_ready is held high before o_valid rises, the result SHALL be consumed on the first OUT cycle.
REQ-017 A verify mismatch SHALL still emit the computed tag, with o_auth_ok = 0.

Reset
REQ-018 rst_n low SHALL asynchronously force:
- state IDLE, counter 0;
- o_valid 0, o_tag 0, o_auth_ok 0, o_ch_id 0;
- Z, V, X = 0.
REQ-019 Reset during MULT or OUT SHALL discard the request; no o_valid pulse SHALL follow.
REQ-020 After deassertion, o_ready SHALL be 1 in the first cycle.

Structure
REQ-021 Package aes_gcm_pkg SHALL hold:
- typedef block_t = logic [0:127];
- constant GCM_R;
- enum tag_state_e (IDLE, MULT, OUT).
REQ-022 One sub-module, gf128_mult_digit, SHALL be used: combinational, parameter DIGIT_BITS, inputs Z, V and the X digit, outputs next Z and next V.
REQ-023 The parent SHALL hold the FSM, counter, capture and output registers.

Verification
REQ-024 NIST GCM test case 1: S=0, len=0, H=66e94bd4ef8a2c3b884cfa59ca342b2e, J0enc=58e2fccefa7e3061367f1d57a4e7455a -> o_tag=58e2fccefa7e3061367f1d57a4e7455a, o_valid N cycles after acceptance.
REQ-025 Identity: H=80000000000000000000000000000000, S=0123456789abcdeffedcba9876543210, len=0, J0enc=0 -> o_tag=0123456789abcdeffedcba9876543210, for every legal DIGIT_BITS.
REQ-026 Verify: the REQ-024 inputs with i_verify=1 and expected=58e2fcce... -> o_auth_ok=1; flip one bit of expected -> o_auth_ok=0, same o_tag.
REQ-027 Backpressure: hold i_out_ready=0 for 10 cycles in OUT; pulse i_valid -> outputs stable, o_ready=0, second request accepted only after drain; o_ch_id values in order.
REQ-028 Reset mid-MULT at counter=N/2 -> outputs 0 immediately, no o_valid; a following request yields a correct tag.
REQ-029 TAG_BITS=96 build with the REQ-024 inputs -> o_tag=58e2fccefa7e3061367f1d57.
